// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bus bundle: unit requests in, grant and broadcast out.
// master = requesting side (execution units), slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned LOCK_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*LOCK_W-1:0] req_index;
  logic [NUM_REQ*DATA_W-1:0] req_result;
  logic [NUM_REQ-1:0]        grnt;
  logic                      cdb_valid;
  logic [LOCK_W-1:0]         cdb_index;
  logic [DATA_W-1:0]         cdb_result;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output req_valid, req_index, req_result,
    input  grnt, cdb_valid, cdb_index, cdb_result, cdb_src
  );

  modport slave (
    input  req_valid, req_index, req_result,
    output grnt, cdb_valid, cdb_index, cdb_result, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter. Grants one ready unit per cycle
// (combinationally) and broadcasts the winner's lock index and result on the
// following cycle. Units retire their granted entry on the same edge.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned LOCK_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NO_LOCK = 0
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SRC_W  = $clog2(NUM_REQ);
  localparam int unsigned CAND_W = SRC_W + 1;
  localparam logic [LOCK_W-1:0] NoLockIdx = LOCK_W'(NO_LOCK);
  localparam logic [SRC_W-1:0]  LastPort  = SRC_W'(NUM_REQ - 1);
  localparam logic [CAND_W-1:0] NumReqC   = CAND_W'(NUM_REQ);

  logic [SRC_W-1:0]  last_q, last_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [LOCK_W-1:0] cdb_index_q, cdb_index_d;
  logic [DATA_W-1:0] cdb_result_q, cdb_result_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [CAND_W-1:0]  cand;
  logic [NUM_REQ-1:0] grnt;
  logic [LOCK_W-1:0]  sel_index;
  logic [DATA_W-1:0]  sel_result;

  // Rotating-priority search starting just after the last winner, ending at it.
  // The extra candidate bit lets the wrap work for non-power-of-two NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + CAND_W'(k);
      if (cand >= NumReqC) cand = cand - NumReqC;
      if (!grant_found && bus.req_valid[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
    // A grant during reset would make a unit retire an entry that is never broadcast.
    if (rst) begin
      grant_found = 1'b0;
      grant_idx   = '0;
    end
  end

  // One-hot grant decode.
  always_comb begin
    grnt = '0;
    if (grant_found) grnt[grant_idx] = 1'b1;
  end

  assign sel_index  = bus.req_index[grant_idx*LOCK_W +: LOCK_W];
  assign sel_result = bus.req_result[grant_idx*DATA_W +: DATA_W];

  // Next broadcast: winner's data, or an idle bus that keeps result/src/pointer.
  always_comb begin
    last_d       = last_q;
    cdb_valid_d  = 1'b0;
    cdb_index_d  = NoLockIdx;
    cdb_result_d = cdb_result_q;
    cdb_src_d    = cdb_src_q;
    if (grant_found) begin
      last_d       = grant_idx;
      cdb_result_d = sel_result;
      cdb_src_d    = grant_idx;
      // A NO_LOCK entry is drained without being broadcast.
      if (sel_index != NoLockIdx) begin
        cdb_valid_d = 1'b1;
        cdb_index_d = sel_index;
      end
    end
  end

  // Pointer and broadcast registers; reset makes port 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= LastPort;
      cdb_valid_q  <= 1'b0;
      cdb_index_q  <= NoLockIdx;
      cdb_result_q <= '0;
      cdb_src_q    <= '0;
    end else begin
      last_q       <= last_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_index_q  <= cdb_index_d;
      cdb_result_q <= cdb_result_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.grnt       = grnt;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_index  = cdb_index_q;
  assign bus.cdb_result = cdb_result_q;
  assign bus.cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, round-robin rotation,
// skip of idle ports, NO_LOCK drain, idle hold, and asynchronous reset.
module tb_cdb_arbiter;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned LOCK_W  = 5;
  localparam int unsigned DATA_W  = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .LOCK_W(LOCK_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LOCK_W (LOCK_W),
    .DATA_W (DATA_W),
    .NO_LOCK(0)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [LOCK_W-1:0] idx, input logic [DATA_W-1:0] res);
    bus.req_valid[p] = 1'b1;
    bus.req_index[p*LOCK_W +: LOCK_W]  = idx;
    bus.req_result[p*DATA_W +: DATA_W] = res;
  endtask

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_index  = '0;
    bus.req_result = '0;
  endtask

  logic [2:0]        exp_g   [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  logic [LOCK_W-1:0] exp_idx [4] = '{5'd2, 5'd3, 5'd1, 5'd2};
  logic [1:0]        exp_src [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_reqs();

    // Reset state; requests during reset must not be granted.
    step();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    #1;
    check("rst_grnt", bus.grnt, 3'b000);
    check("rst_valid", bus.cdb_valid, 1'b0);
    check("rst_index", bus.cdb_index, 5'd0);
    check("rst_result", bus.cdb_result, 32'h0);
    check("rst_src", bus.cdb_src, 2'd0);
    clear_reqs();
    step();
    rst = 1'b0;

    // Single ALU request: granted now, broadcast next cycle, idle after.
    step();
    set_req(0, 5'd5, 32'h0000_0007);
    #1;
    check("t1_grnt", bus.grnt, 3'b001);
    step();
    clear_reqs();
    #1;
    check("t1_valid", bus.cdb_valid, 1'b1);
    check("t1_index", bus.cdb_index, 5'd5);
    check("t1_result", bus.cdb_result, 32'h7);
    check("t1_src", bus.cdb_src, 2'd0);
    step();
    check("t1_idle_valid", bus.cdb_valid, 1'b0);
    check("t1_idle_index", bus.cdb_index, 5'd0);

    // All three request continuously; last=0 so rotation starts at port 1.
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h200);
    set_req(2, 5'd3, 32'h300);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_grnt", bus.grnt, exp_g[c]);
      if (c > 0) begin
        check("rr_index", bus.cdb_index, exp_idx[c-1]);
        check("rr_src", bus.cdb_src, exp_src[c-1]);
        check("rr_valid", bus.cdb_valid, 1'b1);
      end
      step();
    end
    clear_reqs();
    #1;
    check("rr_last_index", bus.cdb_index, 5'd2);
    check("rr_last_result", bus.cdb_result, 32'h200);

    // Bring last to 0, then ports 0 and 2: port 2 wins, then port 0.
    step();
    set_req(0, 5'd6, 32'h60);
    #1;
    check("skip_pre_grnt", bus.grnt, 3'b001);
    step();
    clear_reqs();
    set_req(0, 5'd8, 32'h80);
    set_req(2, 5'd10, 32'hA0);
    #1;
    check("skip_grnt2", bus.grnt, 3'b100);
    step();
    #1;
    check("skip_grnt0", bus.grnt, 3'b001);
    check("skip_index2", bus.cdb_index, 5'd10);
    check("skip_src2", bus.cdb_src, 2'd2);
    step();
    clear_reqs();
    #1;
    check("skip_index0", bus.cdb_index, 5'd8);
    check("skip_src0", bus.cdb_src, 2'd0);

    // NO_LOCK entry from port 1: granted and drained, not broadcast.
    step();
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("nl_grnt", bus.grnt, 3'b010);
    step();
    clear_reqs();
    #1;
    check("nl_valid", bus.cdb_valid, 1'b0);
    check("nl_index", bus.cdb_index, 5'd0);
    check("nl_result", bus.cdb_result, 32'hDEAD_BEEF);
    check("nl_src", bus.cdb_src, 2'd1);

    // Ten idle cycles: bus idle, result and source held.
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_valid", bus.cdb_valid, 1'b0);
      check("idle_index", bus.cdb_index, 5'd0);
      check("idle_result", bus.cdb_result, 32'hDEAD_BEEF);
      check("idle_src", bus.cdb_src, 2'd1);
    end
    // Pointer still 1: ports 0 and 2 pending -> port 2 first. No edge consumed.
    set_req(0, 5'd4, 32'h44);
    set_req(2, 5'd7, 32'h77);
    #1;
    check("idle_ptr_grnt", bus.grnt, 3'b100);
    clear_reqs();

    // Broadcast index 4 from port 0 (last=1 -> search 2,0).
    step();
    set_req(0, 5'd4, 32'h44);
    #1;
    check("ar_pre_grnt", bus.grnt, 3'b001);
    step();
    clear_reqs();
    set_req(1, 5'd9, 32'h99);
    #1;
    check("ar_bcast_valid", bus.cdb_valid, 1'b1);
    check("ar_bcast_index", bus.cdb_index, 5'd4);
    check("ar_grnt_before", bus.grnt, 3'b010);
    // Asynchronous reset mid-cycle.
    #1;
    rst = 1'b1;
    #1;
    check("ar_valid", bus.cdb_valid, 1'b0);
    check("ar_index", bus.cdb_index, 5'd0);
    check("ar_result", bus.cdb_result, 32'h0);
    check("ar_src", bus.cdb_src, 2'd0);
    check("ar_grnt", bus.grnt, 3'b000);
    step();
    check("ar_hold_valid", bus.cdb_valid, 1'b0);
    rst = 1'b0;
    set_req(0, 5'd3, 32'h33);
    set_req(2, 5'd12, 32'hCC);
    #1;
    check("ar_post_grnt", bus.grnt, 3'b001);
    step();
    clear_reqs();
    #1;
    check("ar_post_index", bus.cdb_index, 5'd3);
    check("ar_post_src", bus.cdb_src, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter and broadcast register for the out-of-order core. It collects completed results from the execution units (ALU reservation queue, branch unit, load/store unit), grants exactly one per cycle in round-robin order, and broadcasts the winner's lock index and result one cycle later. The broadcast outputs drive the `cdb_in_index` / `cdb_in_result` inputs of every unit and the register-lock / commit logic. Each execution unit retires its granted entry at the same clock edge the arbiter captures it.

## Interface
Parameters:
- NUM_REQ, 3: number of requesting units; port 0 is the ALU.
- LOCK_W, 5: lock/tag index width; equals `Reg_Lock_Width`.
- DATA_W, 32: result width; equals `Data_Width`.
- NO_LOCK, 0: index value meaning "no lock"; equals `Reg_No_Lock`.

Ports:
- clk  in  1  Single core clock. All state changes on its rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  Bit i set: unit i presents a ready result this cycle. For the ALU this is its `cdb_out_valid`.
- req_index  in  NUM_REQ*LOCK_W  Packed lock indices; unit i occupies bits [i*LOCK_W +: LOCK_W].
- req_result  in  NUM_REQ*DATA_W  Packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- grnt  out  NUM_REQ  One-hot or zero. Combinational. Bit i tells unit i to retire its entry at the next edge.
- cdb_valid  out  1  A broadcast is on the bus this cycle.
- cdb_index  out  LOCK_W  Broadcast lock index. Equals NO_LOCK whenever cdb_valid=0.
- cdb_result  out  DATA_W  Broadcast result.
- cdb_src  out  clog2(NUM_REQ)  Port number of the unit that produced the current broadcast.

## Operation
- State:
  - Round-robin pointer `last` (clog2(NUM_REQ) bits): the most recently granted port.
  - Broadcast registers: cdb_valid, cdb_index, cdb_result, cdb_src.
- Grant selection:
  - Search the ports in order last+1, last+2, …, wrapping modulo NUM_REQ, ending at `last` itself.
  - The first port with req_valid=1 is granted; grnt has that single bit set.
  - No valid request: grnt = 0.
  - While rst=1: grnt = 0, regardless of requests.
- At each clock edge with a grant to port g:
  - last ← g.
  - cdb_index ← req_index[g]; cdb_result ← req_result[g]; cdb_src ← g.
  - cdb_valid ← 1 if req_index[g] != NO_LOCK, else 0.
- Grant with req_index = NO_LOCK:
  - The entry is still granted and the unit drains it.
  - Nothing is broadcast (cdb_valid=0, cdb_index=NO_LOCK).
  - cdb_result and cdb_src still update.
- At each clock edge with no grant:
  - cdb_valid ← 0 and cdb_index ← NO_LOCK.
  - cdb_result, cdb_src and last hold their values.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- The bus cannot be stalled; a broadcast lasts exactly one cycle.
- The arbiter does not latch request data beyond the grant edge. An unrequested port's inputs are don't-care.
- NUM_REQ must be ≥ 2. NUM_REQ need not be a power of two: pointer wrap is by compare-to-(NUM_REQ-1), not bit overflow.

## Timing
- Reset values, applied immediately on rst assertion, without waiting for clk:
  - cdb_valid=0, cdb_index=NO_LOCK, cdb_result=0, cdb_src=0.
  - last=NUM_REQ-1, so port 0 wins first after reset.
- Reset mid-operation:
  - A grant presented in the same cycle as rst is suppressed (grnt=0).
  - No unit retires an entry; nothing is broadcast.
- Latency:
  - Request seen in cycle N → grnt in cycle N (combinational).
  - Broadcast visible in cycle N+1.
  - Units see the result on cdb_in_* in cycle N+1 and may wake dependents then.
- Back-to-back operation: one grant per cycle. Sustained throughput is 1 broadcast/cycle.
- Same-cycle dependency: a unit whose request depends on a value being broadcast this cycle requests no earlier than the following cycle. This is the unit's responsibility; the arbiter does no bypass.

## Test plan
- Reset, then single ALU request:
  - Stimulus: port 0, index 5, result 0x0000_0007 in cycle 1.
  - Required: grnt=3'b001 in cycle 1; cycle 2 cdb_valid=1, cdb_index=5, cdb_result=7, cdb_src=0.
  - Required: cycle 3 cdb_valid=0, cdb_index=0.
- All three ports request continuously with distinct indices 1/2/3:
  - Required: grants 001,010,100,001,… in successive cycles.
  - Required: broadcasts indices 1,2,3,1 one cycle later each.
- Ports 0 and 2 request while last=0:
  - Required: grant goes to port 2 (skips idle port 1).
  - Required: next cycle, port 0 is granted.
- Granted request carries index NO_LOCK (0) with result 0xDEAD_BEEF:
  - Required: grnt set for that port; next cycle cdb_valid=0 and cdb_index=0.
  - Required: cdb_result=0xDEADBEEF.
- Assert rst asynchronously mid-cycle while a broadcast of index 4 is active and port 1 is requesting:
  - Required: outputs drop to their reset values before the next edge, and grnt=0.
  - Required: after release, port 0 has priority.
- No requests for 10 cycles after traffic:
  - Required: cdb_valid=0 and cdb_index=0 throughout.
  - Required: cdb_result holds its last value; pointer unchanged.
